// File: rtl/inc_share_pkg.sv
// rtl/inc_share_pkg.sv - shared types, defaults and round-robin pick function for inc_share_arb
package inc_share_pkg;

  // Output register occupancy
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 8;
  // Widest arbiter the pick function supports
  localparam int MAXREQ   = 16;

  // One-hot grant on the first set bit of valid at or after ptr, wrapping at n
  function automatic logic [MAXREQ-1:0] rr_pick(input logic [MAXREQ-1:0] valid,
                                                input logic [3:0]        ptr,
                                                input logic [4:0]        n);
    logic [MAXREQ-1:0] grant;
    logic              found;
    logic [4:0]        idx;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < MAXREQ; k++) begin
      idx = {1'b0, ptr} + 5'(k);
      if (idx >= n) idx = idx - n;
      if ((5'(k) < n) && !found && valid[idx[3:0]]) begin
        grant[idx[3:0]] = 1'b1;
        found           = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/inc_rr_arb.sv
// rtl/inc_rr_arb.sv - NREQ-way round-robin arbiter, one-hot grant gated by advance
module inc_rr_arb
  import inc_share_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic            advance,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant
);

  logic [MAXREQ-1:0] grant_all;

  assign grant_all = rr_pick(MAXREQ'(valid), 4'(ptr), 5'(NREQ));
  assign grant     = advance ? grant_all[NREQ-1:0] : '0;

  // Lanes above NREQ are never granted; they exist only because the pick is sized for the widest arbiter
  if (NREQ < MAXREQ) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^grant_all[MAXREQ-1:NREQ];
  end

endmodule

// File: rtl/inc_share_arb.sv
// rtl/inc_share_arb.sv - shared incrementer with round-robin arbitration; INC_SAT_EN selects saturating mode
module inc_share_arb
  import inc_share_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  parameter  int W    = W_DEF,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [W-1:0]    rsp_data,
  output logic [IDW-1:0]  rsp_id,
  output logic            rsp_carry
);

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   ptr;
  logic             can_accept;
  logic             advance;
  logic             any_grant;
  logic [NREQ-1:0]  grant;
  logic [W-1:0]     op;
  logic [IDW-1:0]   gid;
  logic [W:0]       sum;
  logic [W-1:0]     res_data;
  logic             res_carry;

  // The register can take a new result when empty or when its current one leaves this cycle
  assign can_accept = (state == EMPTY) | rsp_ready;
  assign advance    = can_accept & ~rst;

  inc_rr_arb #(.NREQ(NREQ)) u_arb (
    .valid   (req_valid),
    .advance (advance),
    .ptr     (ptr),
    .grant   (grant)
  );

  assign req_ready = grant;
  assign any_grant = |grant;
  assign rsp_valid = (state == FULL);

  // Operand mux and id encode from the one-hot grant
  always_comb begin
    op  = '0;
    gid = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        op  = op | req_data[i*W +: W];
        gid = gid | IDW'(i);
      end
    end
  end

  assign sum = {1'b0, op} + {{W{1'b0}}, 1'b1};

`ifdef INC_SAT_EN
  // All-ones operand sticks at all-ones; carry flags the saturation
  assign res_data  = sum[W] ? {W{1'b1}} : sum[W-1:0];
  assign res_carry = sum[W];
`else
  assign res_data  = sum[W-1:0];
  assign res_carry = sum[W];
`endif

  // Output register occupancy state
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Next occupancy: fill on grant, drain when consumed without a refill
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (any_grant) state_nxt = FULL;
      FULL:    if (rsp_ready && !any_grant) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Result register loads whenever a transfer happens; held otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_carry <= 1'b0;
    end else if (any_grant) begin
      rsp_data  <= res_data;
      rsp_id    <= gid;
      rsp_carry <= res_carry;
    end
  end

  // Pointer moves just past the requester that was served
  always_ff @(posedge clk) begin
    if (rst)            ptr <= '0;
    else if (any_grant) ptr <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
  end

endmodule
